// File: rtl/alu_result_streamer.sv
// alu_result_streamer
// Consumer-side reader for the matrix ALU result bus. On a rising edge of the
// ALU's done level, it snapshots the result (an n x n matrix or a determinant
// scalar) and the overflow flag. It then streams the valid elements one per
// valid/ready handshake. Matrix elements go out in row-major order; a
// determinant goes out as a single beat.
//
// Ports:
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   done                 ALU completion level (only rising edges act)
//   opcode               3'b000 no-op, 3'b111 determinant, others matrix
//   matrix_size          n, legal 2..MAX_N
//   C_flat               matrix result, element (r,c) at (r*MAX_N+c)*ELEM_W
//   number               scalar (determinant) result
//   overflow_flag        ALU overflow
//   out_data/out_index   current element and flat slot index r*MAX_N+c
//   out_valid/out_ready  stream handshake
//   out_last             current beat is the final one
//   out_overflow         captured overflow, held until next accepted capture
//   busy                 stream or finish in progress
//   stream_done          pulse after the final handshake
//   size_error           pulse when a capture is rejected for illegal size
//   overrun              pulse when a done rise is ignored while busy
module alu_result_streamer #(
  parameter int MAX_N  = 5,
  parameter int ELEM_W = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          done,
  input  logic [2:0]                    opcode,
  input  logic [2:0]                    matrix_size,
  input  logic [MAX_N*MAX_N*ELEM_W-1:0] C_flat,
  input  logic [ELEM_W-1:0]             number,
  input  logic                          overflow_flag,
  output logic [ELEM_W-1:0]             out_data,
  output logic [4:0]                    out_index,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          out_overflow,
  output logic                          busy,
  output logic                          stream_done,
  output logic                          size_error,
  output logic                          overrun
);

  localparam int NE = MAX_N * MAX_N;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FINISH
  } state_e;

  state_e            state_q, state_d;
  logic              done_s_q, done_s_d;
  logic              done_d_q, done_d_d;
  logic [ELEM_W-1:0] elem_q [NE];
  logic [ELEM_W-1:0] elem_d [NE];
  logic [ELEM_W-1:0] num_q, num_d;
  logic              det_q, det_d;
  logic              ovf_q, ovf_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        r_q, r_d;
  logic [2:0]        c_q, c_d;
  logic              size_err_q, size_err_d;
  logic              overrun_q, overrun_d;

  logic              done_rise;
  logic              size_ok;
  logic              last_beat;
  logic              handshake;
  logic [4:0]        idx;

  // done is registered once before edge detection, so a rise sampled at
  // edge k is acted on at edge k+1.
  assign done_rise = done_s_q & ~done_d_q;
  assign size_ok   = (matrix_size >= 3'd2) && (matrix_size <= 3'(MAX_N));
  assign idx       = 5'(r_q) * 5'(MAX_N) + 5'(c_q);
  assign last_beat = det_q | ((r_q == n_q - 3'd1) && (c_q == n_q - 3'd1));
  assign handshake = out_valid & out_ready;

  assign out_valid    = (state_q == S_STREAM);
  assign busy         = (state_q != S_IDLE);
  assign stream_done  = (state_q == S_FINISH);
  assign out_last     = out_valid & last_beat;
  assign out_index    = out_valid ? idx : '0;
  assign out_data     = !out_valid ? '0 : (det_q ? num_q : elem_q[idx]);
  assign out_overflow = ovf_q;
  assign size_error   = size_err_q;
  assign overrun      = overrun_q;

  always_comb begin
    state_d    = state_q;
    done_s_d   = done;
    done_d_d   = done_s_q;
    elem_d     = elem_q;
    num_d      = num_q;
    det_d      = det_q;
    ovf_d      = ovf_q;
    n_d        = n_q;
    r_d        = r_q;
    c_d        = c_q;
    size_err_d = 1'b0;
    overrun_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (done_rise) begin
          if (opcode == 3'b111) begin
            num_d   = number;
            ovf_d   = overflow_flag;
            det_d   = 1'b1;
            r_d     = '0;
            c_d     = '0;
            state_d = S_STREAM;
          end else if (opcode != 3'b000) begin
            if (size_ok) begin
              for (int unsigned i = 0; i < NE; i++) begin
                elem_d[i] = C_flat[i*ELEM_W +: ELEM_W];
              end
              ovf_d   = overflow_flag;
              det_d   = 1'b0;
              n_d     = matrix_size;
              r_d     = '0;
              c_d     = '0;
              state_d = S_STREAM;
            end else begin
              size_err_d = 1'b1;
            end
          end
        end
      end
      S_STREAM: begin
        if (done_rise) overrun_d = 1'b1;
        if (handshake) begin
          if (last_beat) begin
            r_d     = '0;
            c_d     = '0;
            state_d = S_FINISH;
          end else if (c_q == n_q - 3'd1) begin
            c_d = '0;
            r_d = r_q + 3'd1;
          end else begin
            c_d = c_q + 3'd1;
          end
        end
      end
      S_FINISH: begin
        if (done_rise) overrun_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      done_s_q   <= 1'b0;
      done_d_q   <= 1'b0;
      for (int unsigned i = 0; i < NE; i++) elem_q[i] <= '0;
      num_q      <= '0;
      det_q      <= 1'b0;
      ovf_q      <= 1'b0;
      n_q        <= '0;
      r_q        <= '0;
      c_q        <= '0;
      size_err_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_s_q   <= done_s_d;
      done_d_q   <= done_d_d;
      elem_q     <= elem_d;
      num_q      <= num_d;
      det_q      <= det_d;
      ovf_q      <= ovf_d;
      n_q        <= n_d;
      r_q        <= r_d;
      c_q        <= c_d;
      size_err_q <= size_err_d;
      overrun_q  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_alu_result_streamer.sv
module tb_alu_result_streamer;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         done;
  logic [2:0]   opcode;
  logic [2:0]   matrix_size;
  logic [199:0] C_flat;
  logic [7:0]   number;
  logic         overflow_flag;
  logic [7:0]   out_data;
  logic [4:0]   out_index;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         out_overflow;
  logic         busy;
  logic         stream_done;
  logic         size_error;
  logic         overrun;

  alu_result_streamer #(.MAX_N(5), .ELEM_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .done(done), .opcode(opcode),
    .matrix_size(matrix_size), .C_flat(C_flat), .number(number),
    .overflow_flag(overflow_flag), .out_data(out_data), .out_index(out_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_overflow(out_overflow), .busy(busy), .stream_done(stream_done),
    .size_error(size_error), .overrun(overrun)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] data;
    logic [4:0] idx;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  logic  exp_ovf = 1'b0;
  int    checks = 0, errors = 0;
  int    sd_cnt = 0, se_cnt = 0, ov_cnt = 0, v_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Model: the expected beat list for a capture, from the opcode/size rules.
  task automatic model_capture(input logic [2:0] op, input logic [2:0] sz,
                               input logic [199:0] cf, input logic [7:0] num,
                               input logic ovf, output bit serr);
    serr = 1'b0;
    if (op == 3'b000) return;
    if (op == 3'b111) begin
      exp_q.push_back(beat_t'{data: num, idx: 5'd0, last: 1'b1});
      exp_ovf = ovf;
    end else if (sz >= 2 && sz <= 5) begin
      for (int r = 0; r < int'(sz); r++)
        for (int c = 0; c < int'(sz); c++)
          exp_q.push_back(beat_t'{data: cf[(r*5+c)*8 +: 8], idx: 5'(r*5+c),
                                  last: (r == int'(sz)-1) && (c == int'(sz)-1)});
      exp_ovf = ovf;
    end else begin
      serr = 1'b1;
    end
  endtask

  function automatic logic [199:0] put(input logic [199:0] v, input int r,
                                       input int c, input logic [7:0] d);
    v[(r*5+c)*8 +: 8] = d;
    return v;
  endfunction

  // Per-cycle compare against the model queue.
  logic        prev_hs_last = 1'b0;
  logic        prev_stall = 1'b0;
  logic [13:0] prev_beat = '0;
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_hs_last = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      chk("stream_done_timing", stream_done, prev_hs_last);
      if (stream_done) sd_cnt++;
      if (size_error)  se_cnt++;
      if (overrun)     ov_cnt++;
      if (out_valid) begin
        v_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", out_valid, 1'b0);
        end else begin
          chk("out_data", out_data, exp_q[0].data);
          chk("out_index", out_index, exp_q[0].idx);
          chk("out_last", out_last, exp_q[0].last);
          chk("out_overflow", out_overflow, exp_ovf);
          chk("busy_in_stream", busy, 1'b1);
          if (prev_stall) chk("stall_hold", {out_data, out_index, out_last}, prev_beat);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_hs_last = out_valid && out_ready && out_last;
      prev_stall   = out_valid && !out_ready;
      prev_beat    = {out_data, out_index, out_last};
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic start(input logic [2:0] op, input logic [2:0] sz,
                       input logic [199:0] cf, input logic [7:0] num,
                       input logic ovf, output bit serr);
    done = 1'b0;
    cyc(3);
    opcode = op; matrix_size = sz; C_flat = cf; number = num; overflow_flag = ovf;
    model_capture(op, sz, cf, num, ovf, serr);
    done = 1'b1;
  endtask

  task automatic wait_end(input string name);
    int s = sd_cnt;
    int n = 0;
    while (sd_cnt == s && n < 300) begin
      cyc(1);
      n++;
    end
    chk({name, "_stream_done_count"}, sd_cnt - s, 1);
    chk({name, "_beats_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_index(input logic [4:0] ix);
    int n = 0;
    while (!(out_valid && out_index == ix) && n < 100) begin
      cyc(1);
      n++;
    end
    chk("wait_index_reached", out_index, ix);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_out_data"}, out_data, 0);
    chk({name, "_out_index"}, out_index, 0);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_out_last"}, out_last, 0);
    chk({name, "_out_overflow"}, out_overflow, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_stream_done"}, stream_done, 0);
    chk({name, "_size_error"}, size_error, 0);
    chk({name, "_overrun"}, overrun, 0);
  endtask

  initial begin
    logic [199:0] cf;
    bit serr;
    int s0, o0, v0, stalls, n;

    reset_n = 1'b0; done = 1'b0; opcode = '0; matrix_size = '0; C_flat = '0;
    number = '0; overflow_flag = 1'b0; out_ready = 1'b1;
    #12;
    chk_all_zero("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    cyc(2);

    // 2x2 add, done held high through the whole stream
    cf = '0;
    cf = put(cf, 0, 0, 8'h03); cf = put(cf, 0, 1, 8'h07);
    cf = put(cf, 1, 0, 8'h02); cf = put(cf, 1, 1, 8'h05);
    o0 = ov_cnt; v0 = v_cnt;
    start(3'b001, 3'd2, cf, 8'h00, 1'b0, serr);
    chk("model_2x2_b0", exp_q[0], {8'h03, 5'd0, 1'b0});
    chk("model_2x2_b1", exp_q[1], {8'h07, 5'd1, 1'b0});
    chk("model_2x2_b2", exp_q[2], {8'h02, 5'd5, 1'b0});
    chk("model_2x2_b3", exp_q[3], {8'h05, 5'd6, 1'b1});
    wait_end("add2x2");
    chk("add2x2_valid_cycles", v_cnt - v0, 4);
    chk("add2x2_no_overrun", ov_cnt - o0, 0);

    // Determinant
    start(3'b111, 3'd0, '0, 8'hFE, 1'b1, serr);
    chk("model_det", exp_q[0], {8'hFE, 5'd0, 1'b1});
    wait_end("det");
    chk("det_overflow_held", out_overflow, 1'b1);
    chk("det_idle_busy", busy, 1'b0);

    // 5x5 with 3 cycles of backpressure on index 12
    cf = '0;
    for (int i = 0; i < 25; i++) cf[i*8 +: 8] = 8'(i);
    v0 = v_cnt;
    start(3'b010, 3'd5, cf, 8'h00, 1'b0, serr);
    chk("model_5x5_b12", exp_q[12], {8'h0C, 5'd12, 1'b0});
    chk("model_5x5_b24", exp_q[24], {8'h18, 5'd24, 1'b1});
    s0 = sd_cnt; stalls = 0; n = 0;
    while (sd_cnt == s0 && n < 300) begin
      @(posedge clock); #1;
      if (out_valid && out_index == 5'd12 && stalls < 3) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
      end
      n++;
    end
    chk("bp5x5_stream_done_count", sd_cnt - s0, 1);
    chk("bp5x5_beats_left", exp_q.size(), 0);
    chk("bp5x5_valid_cycles", v_cnt - v0, 28);
    chk("bp5x5_overflow", out_overflow, 1'b0);

    // Illegal size: rejected, overflow not captured
    s0 = se_cnt;
    start(3'b001, 3'd6, cf, 8'h00, 1'b1, serr);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("illegal_busy", busy, 1'b0);
      chk("illegal_valid", out_valid, 1'b0);
    end
    chk("illegal_size_error_pulses", se_cnt - s0, serr ? 1 : 0);
    chk("illegal_overflow_kept", out_overflow, 1'b0);

    // No-op opcode is ignored
    s0 = se_cnt;
    start(3'b000, 3'd3, cf, 8'h00, 1'b1, serr);
    cyc(8);
    chk("noop_busy", busy, 1'b0);
    chk("noop_size_error", se_cnt - s0, 0);

    // Overrun at beat 2 of a 3x3 stream, live bus changed
    cf = '0;
    for (int i = 0; i < 25; i++) cf[i*8 +: 8] = 8'h10 + 8'(i);
    o0 = ov_cnt;
    start(3'b011, 3'd3, cf, 8'h00, 1'b0, serr);
    wait_index(5'd2);
    done = 1'b0;
    cyc(1);
    C_flat = ~cf; number = 8'h55; done = 1'b1;
    wait_end("overrun3x3");
    chk("overrun_pulses", ov_cnt - o0, 1);

    // Reset in the middle of a 4x4 stream
    start(3'b001, 3'd4, cf, 8'h00, 1'b1, serr);
    wait_index(5'd3);
    s0 = sd_cnt;
    #2;
    reset_n = 1'b0;
    done = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_q.delete();
    exp_ovf = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    cyc(4);
    chk("midreset_no_stream_done", sd_cnt - s0, 0);
    chk("midreset_valid_low", out_valid, 1'b0);

    cf = '0;
    cf = put(cf, 0, 0, 8'hA1); cf = put(cf, 0, 1, 8'hB2);
    cf = put(cf, 1, 0, 8'hC3); cf = put(cf, 1, 1, 8'hD4);
    start(3'b100, 3'd2, cf, 8'h00, 1'b0, serr);
    wait_end("after_reset2x2");

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
